// File: rtl/fb_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pixel_writer
//  Description : Write side of the TFT-LCD frame buffer. Turns a raster-ordered
//                RGB565 pixel stream, or a solid-colour fill command, into
//                BRAM write-port transactions. The BRAM address (x + y*H_ACTIVE)
//                is generated here with running adders only.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_pixel_writer #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 16
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DATA_W-1:0] S_DATA,
  input  logic              S_SOF,
  input  logic              S_EOL,
  input  logic              FILL_START,
  input  logic [DATA_W-1:0] FILL_COLOR,
  input  logic              ERR_CLR,
  output logic              BRAMWE,
  output logic [ADDR_W-1:0] BRAMADDR,
  output logic [DATA_W-1:0] BRAMDIN,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              ERR_LINE
);

  // The whole frame must be addressable by the BRAM port.
  generate
    if (longint'(H_ACTIVE) * longint'(V_ACTIVE) > (longint'(1) << ADDR_W)) begin : g_size_check
      $error("fb_pixel_writer: H_ACTIVE*V_ACTIVE does not fit in ADDR_W address bits");
    end
  endgenerate

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [XW-1:0]     X_LAST    = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] H_STEP    = ADDR_W'(H_ACTIVE);

  localparam logic [1:0] ST_WAIT_SOF = 2'd0;
  localparam logic [1:0] ST_STREAM   = 2'd1;
  localparam logic [1:0] ST_FILL     = 2'd2;

  logic [1:0]        state,      state_d;
  logic [XW-1:0]     x_cnt,      x_cnt_d;
  logic [YW-1:0]     y_cnt,      y_cnt_d;
  logic [ADDR_W-1:0] addr,       addr_d;
  logic [ADDR_W-1:0] line_base,  line_base_d;   // y*H_ACTIVE, kept as a running sum
  logic [DATA_W-1:0] fill_color, fill_color_d;
  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              done_d;
  logic              err_set;
  logic              err_d;
  logic              busy_d;
  logic              accept;

  // Fill has priority over the stream in WAIT_SOF, so the beat is held off that cycle.
  assign S_READY = (state == ST_STREAM) || ((state == ST_WAIT_SOF) && !FILL_START);
  assign accept  = S_VALID && S_READY;

  // Next-state, counter and write-port decode.
  always_comb begin
    state_d      = state;
    x_cnt_d      = x_cnt;
    y_cnt_d      = y_cnt;
    addr_d       = addr;
    line_base_d  = line_base;
    fill_color_d = fill_color;
    we_d         = 1'b0;
    waddr_d      = BRAMADDR;
    wdata_d      = BRAMDIN;
    done_d       = 1'b0;
    err_set      = 1'b0;

    case (state)
      ST_WAIT_SOF: begin
        if (FILL_START) begin
          fill_color_d = FILL_COLOR;
          addr_d       = '0;
          state_d      = ST_FILL;
        end else if (accept && S_SOF) begin
          // Pixel (0,0) is written now; the counters point at (1,0).
          we_d        = 1'b1;
          waddr_d     = '0;
          wdata_d     = S_DATA;
          x_cnt_d     = XW'(1);
          y_cnt_d     = '0;
          addr_d      = ADDR_W'(1);
          line_base_d = '0;
          state_d     = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (accept) begin
          we_d    = 1'b1;
          wdata_d = S_DATA;
          if (S_SOF) begin
            // Unexpected frame start: resynchronise on this beat as pixel (0,0).
            waddr_d     = '0;
            err_set     = 1'b1;
            x_cnt_d     = XW'(1);
            y_cnt_d     = '0;
            addr_d      = ADDR_W'(1);
            line_base_d = '0;
          end else begin
            waddr_d = addr;
            if ((x_cnt == X_LAST) || S_EOL) begin
              // Line ends here; mismatch between EOL and position is a framing error.
              err_set = (x_cnt == X_LAST) ^ S_EOL;
              if (y_cnt == Y_LAST) begin
                done_d      = 1'b1;
                x_cnt_d     = '0;
                y_cnt_d     = '0;
                addr_d      = '0;
                line_base_d = '0;
                state_d     = ST_WAIT_SOF;
              end else begin
                // Realign to the next line start, which also covers early EOL.
                x_cnt_d     = '0;
                y_cnt_d     = y_cnt + YW'(1);
                addr_d      = line_base + H_STEP;
                line_base_d = line_base + H_STEP;
              end
            end else begin
              x_cnt_d = x_cnt + XW'(1);
              addr_d  = addr + ADDR_W'(1);
            end
          end
        end
      end

      ST_FILL: begin
        we_d    = 1'b1;
        waddr_d = addr;
        wdata_d = fill_color;
        if (addr == ADDR_LAST) begin
          done_d  = 1'b1;
          addr_d  = '0;
          state_d = ST_WAIT_SOF;
        end else begin
          addr_d = addr + ADDR_W'(1);
        end
      end

      default: begin
        state_d = ST_WAIT_SOF;
        x_cnt_d = '0;
        y_cnt_d = '0;
        addr_d  = '0;
      end
    endcase

    // A new error in the clearing cycle wins.
    err_d  = (ERR_LINE && !ERR_CLR) || err_set;
    busy_d = (state_d != ST_WAIT_SOF);
  end

  // State, counters and registered write port.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state      <= ST_WAIT_SOF;
      x_cnt      <= '0;
      y_cnt      <= '0;
      addr       <= '0;
      line_base  <= '0;
      fill_color <= '0;
      BRAMWE     <= 1'b0;
      BRAMADDR   <= '0;
      BRAMDIN    <= '0;
      FRAME_DONE <= 1'b0;
      ERR_LINE   <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      state      <= state_d;
      x_cnt      <= x_cnt_d;
      y_cnt      <= y_cnt_d;
      addr       <= addr_d;
      line_base  <= line_base_d;
      fill_color <= fill_color_d;
      BRAMWE     <= we_d;
      BRAMADDR   <= waddr_d;
      BRAMDIN    <= wdata_d;
      FRAME_DONE <= done_d;
      ERR_LINE   <= err_d;
      BUSY       <= busy_d;
    end
  end

endmodule
`default_nettype wire
